// File: rtl/ttl_rr_bus_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ttl_arb_defs : shared state encodings and index-width helper for the     |
// |                round-robin bus arbiter.                                  |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
package ttl_arb_defs;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } arb_state_t;

  // Index width for n items, never narrower than one bit.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ttl_rr_bus_arbiter_pick.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ttl_rr_pick : combinational rotating-priority picker; the first valid    |
// |               bit at or after ptr (modulo BLOCKS) wins.                  |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module ttl_rr_pick
  import ttl_arb_defs::*;
#(
  parameter int BLOCKS = 4
) (
  input  logic [BLOCKS-1:0]         valid,
  input  logic [clog2(BLOCKS)-1:0]  ptr,
  output logic                      any,
  output logic [clog2(BLOCKS)-1:0]  winner
);

  localparam int W = clog2(BLOCKS);

  logic [W-1:0] w_idx;

  // Scan from the farthest rotation back to ptr so the nearest hit is kept.
  always_comb begin
    winner = '0;
    w_idx  = '0;
    for (int k = BLOCKS - 1; k >= 0; k--) begin
      w_idx = W'((int'(ptr) + k) % BLOCKS);
      if (valid[w_idx]) winner = w_idx;
    end
  end

  assign any = |valid;

endmodule
`default_nettype wire

// File: rtl/ttl_rr_bus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ttl_rr_bus_arbiter : TTL-style round-robin owner sequencer for a shared  |
// |   wired-OR bus, with one dead cycle between owners.                      |
// |   Optional hold-time limit: define TTL_ARB_TIMEOUT_EN.                   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module ttl_rr_bus_arbiter
  import ttl_arb_defs::*;
#(
  parameter int BLOCKS     = 4,
  parameter int TIMEOUT    = 16,
  parameter int DELAY_RISE = 0,
  parameter int DELAY_FALL = 0
) (
  input  logic                      Clk,
  input  logic                      Clear_bar,
  input  logic [BLOCKS-1:0]         Req_bar,
  input  logic                      Done_bar,
  output logic [BLOCKS-1:0]         Grant_bar,
  output logic [clog2(BLOCKS)-1:0]  Enc,
  output logic                      Busy,
  output logic                      Timeout
);

  localparam int ENC_W = clog2(BLOCKS);
  localparam int DLY_D = (DELAY_RISE > DELAY_FALL) ? DELAY_RISE : DELAY_FALL;

  if (BLOCKS < 2 || BLOCKS > 16 || TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_params
    $error("ttl_rr_bus_arbiter: BLOCKS or TIMEOUT out of range");
  end

  logic [BLOCKS-1:0] w_req_valid;
  logic              w_done;
  logic              w_any;
  logic [ENC_W-1:0]  w_win;
  logic [ENC_W-1:0]  w_ptr_next;
  logic              w_own_valid;
  logic              w_expired;
  logic              w_release;

  arb_state_t        r_state;
  logic [ENC_W-1:0]  r_ptr;
  logic [ENC_W-1:0]  r_enc;
  logic [BLOCKS-1:0] r_gnt_bar;
  logic              r_busy;

  // Pull-up semantics: only a clean 0 is asserted; Z and X read as idle.
  for (genvar i = 0; i < BLOCKS; i++) begin : g_decode
    assign w_req_valid[i] = (Req_bar[i] === 1'b0);
  end
  assign w_done = (Done_bar === 1'b0);

  ttl_rr_pick #(
    .BLOCKS (BLOCKS)
  ) u_pick (
    .valid  (w_req_valid),
    .ptr    (r_ptr),
    .any    (w_any),
    .winner (w_win)
  );

  assign w_own_valid = w_req_valid[r_enc];
  assign w_ptr_next  = (r_enc == ENC_W'(BLOCKS - 1)) ? '0 : r_enc + 1'b1;

`ifdef TTL_ARB_TIMEOUT_EN
  logic [7:0] r_hold;
  logic       r_timeout;
  assign w_expired = (r_hold == 8'(TIMEOUT - 1));
  assign Timeout   = r_timeout;
`else
  assign w_expired = 1'b0;
  assign Timeout   = 1'b0;
`endif

  assign w_release = w_done | ~w_own_valid | w_expired;

  always_ff @(posedge Clk or negedge Clear_bar) begin
    if (!Clear_bar) begin
      r_state   <= ST_IDLE;
      r_ptr     <= '0;
      r_enc     <= '0;
      r_gnt_bar <= '1;
      r_busy    <= 1'b0;
`ifdef TTL_ARB_TIMEOUT_EN
      r_hold    <= '0;
      r_timeout <= 1'b0;
`endif
    end else begin
`ifdef TTL_ARB_TIMEOUT_EN
      r_timeout <= 1'b0;
`endif
      case (r_state)
        ST_IDLE, ST_TURN: begin
          if (w_any) begin
            r_state   <= ST_GRANT;
            r_gnt_bar <= ~(BLOCKS'(1) << w_win);
            r_enc     <= w_win;
            r_busy    <= 1'b1;
`ifdef TTL_ARB_TIMEOUT_EN
            r_hold    <= '0;
`endif
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_GRANT: begin
          if (w_release) begin
            r_state   <= ST_TURN;
            r_gnt_bar <= '1;
            r_ptr     <= w_ptr_next;
`ifdef TTL_ARB_TIMEOUT_EN
            // A simultaneous Done or withdrawal is a normal release.
            r_timeout <= w_expired & ~w_done & w_own_valid;
`endif
          end
`ifdef TTL_ARB_TIMEOUT_EN
          else begin
            r_hold <= r_hold + 8'd1;
          end
`endif
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign Enc  = r_enc;
  assign Busy = r_busy;

  // Pin delays are counted in Clk periods; internal state never sees them.
  if (DELAY_RISE == 0 && DELAY_FALL == 0) begin : g_no_delay
    assign Grant_bar = r_gnt_bar;
  end else begin : g_delay
    localparam int RI = (DELAY_RISE > 0) ? DELAY_RISE - 1 : 0;
    localparam int FI = (DELAY_FALL > 0) ? DELAY_FALL - 1 : 0;

    logic [BLOCKS-1:0] r_tap [DLY_D];
    logic [BLOCKS-1:0] r_out;
    logic [BLOCKS-1:0] w_rise;
    logic [BLOCKS-1:0] w_fall;

    always_ff @(posedge Clk or negedge Clear_bar) begin
      if (!Clear_bar) begin
        for (int k = 0; k < DLY_D; k++) r_tap[k] <= '1;
        r_out <= '1;
      end else begin
        r_tap[0] <= r_gnt_bar;
        for (int k = 1; k < DLY_D; k++) r_tap[k] <= r_tap[k-1];
        r_out <= Grant_bar;
      end
    end

    assign w_rise    = (DELAY_RISE == 0) ? r_gnt_bar : r_tap[RI];
    assign w_fall    = (DELAY_FALL == 0) ? r_gnt_bar : r_tap[FI];
    assign Grant_bar = (r_out & w_fall) | (~r_out & w_rise);
  end

endmodule
`default_nettype wire
